// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: sequences START, DATA (LSB first), optional PARITY
// and STOP through a five-state FSM. It drives the select for an external TX mux.
// Optional feature macro: UART_TX_BACK2BACK_EN. When it is defined, a request
// seen in STOP chains the next frame directly into START with no IDLE gap.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            MUX_Sel,
  output logic                  Start_Bit,
  output logic                  Stop_Bit,
  output logic                  Ser_Data,
  output logic                  Par_Bit,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_PARITY = 2'b11;
  localparam logic [1:0] SEL_STOP   = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   par_en_q, par_en_d;
  logic                   par_typ_q, par_typ_d;
  logic                   par_bit_q, par_bit_d;
  logic [1:0]             mux_sel_q, mux_sel_d;
  logic                   busy_q, busy_d;
  logic                   load;

  // A new word is accepted in IDLE, and also in STOP when frames may be chained.
  always_comb begin
`ifdef UART_TX_BACK2BACK_EN
    load = Data_Valid && ((state_q == IDLE) || (state_q == STOP));
`else
    load = Data_Valid && (state_q == IDLE);
`endif
  end

  // Next-state, datapath and registered-output decode for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    par_bit_d = par_bit_q;

    unique case (state_q)
      IDLE:   state_d = IDLE;
      START: begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        shift_d = shift_q >> 1;
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: state_d = STOP;
      STOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Capturing the word freezes the parity controls for the whole frame.
    if (load) begin
      shift_d   = P_DATA;
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      par_bit_d = (^P_DATA) ^ PAR_TYP;
      cnt_d     = '0;
      state_d   = START;
    end

    unique case (state_d)
      START:   mux_sel_d = SEL_START;
      DATA:    mux_sel_d = SEL_DATA;
      PARITY:  mux_sel_d = SEL_PARITY;
      default: mux_sel_d = SEL_STOP;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bit_q <= 1'b0;
      mux_sel_q <= SEL_STOP;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      par_bit_q <= par_bit_d;
      mux_sel_q <= mux_sel_d;
      busy_q    <= busy_d;
    end
  end

  assign MUX_Sel   = mux_sel_q;
  assign Busy      = busy_q;
  assign Par_Bit   = par_bit_q;
  assign Ser_Data  = shift_q[0];
  assign Start_Bit = 1'b0;
  assign Stop_Bit  = 1'b1;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: directed frames plus randomized frames
// compared against a frame-level reference built from the protocol rules.
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic [1:0]   MUX_Sel;
  logic         Start_Bit;
  logic         Stop_Bit;
  logic         Ser_Data;
  logic         Par_Bit;
  logic         Busy;

  int checkCount = 0;
  int errorCount = 0;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .MUX_Sel    (MUX_Sel),
    .Start_Bit  (Start_Bit),
    .Stop_Bit   (Stop_Bit),
    .Ser_Data   (Ser_Data),
    .Par_Bit    (Par_Bit),
    .Busy       (Busy)
  );

  // Free-running 100 MHz clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count a comparison and report it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Parity as a count of ones in the word, inverted for odd parity.
  function automatic logic refParity(input logic [W-1:0] d, input logic odd);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(d[i]);
    return logic'(ones % 2) ^ odd;
  endfunction

  // Expected TX mux select for position k of a frame: start, data bits, parity, stop.
  function automatic logic [1:0] refMux(input int k, input logic pen);
    if (k == 0) return 2'b00;
    if (k <= W) return 2'b01;
    if (pen && k == W + 1) return 2'b11;
    return 2'b10;
  endfunction

  // Launch one frame and check every frame cycle against the reference.
  // disturbAt: frame cycle during which a bogus request is injected (-1 = none).
  // chainNext: hold a request for nextData across the tail of this frame.
  // abortAt:   frame cycle in which reset is pulsed (-1 = none).
  task automatic applyStimulus(input logic [W-1:0] data, input logic pen, input logic ptyp,
                               input int disturbAt, input bit chainNext,
                               input logic [W-1:0] nextData, input int abortAt);
    int          len;
    logic        expPar;
    logic [31:0] r;
    len    = 2 + W + int'(pen);
    expPar = refParity(data, ptyp);
    P_DATA     = data;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      checkOutput("busy", 32'(Busy), 32'(1));
      checkOutput("mux", 32'(MUX_Sel), 32'(refMux(k, pen)));
      checkOutput("parbit", 32'(Par_Bit), 32'(expPar));
      if (k >= 1 && k <= W) checkOutput("serdata", 32'(Ser_Data), 32'(data[k-1]));
      if (k == abortAt) begin
        #2 RST = 1'b0;
        #1;
        checkOutput("abort_mux", 32'(MUX_Sel), 32'(2'b10));
        checkOutput("abort_busy", 32'(Busy), 32'(0));
        checkOutput("abort_ser", 32'(Ser_Data), 32'(0));
        checkOutput("abort_par", 32'(Par_Bit), 32'(0));
        return;
      end
      if (k == disturbAt) begin
        r          = $urandom;
        Data_Valid = 1'b1;
        P_DATA     = r[W-1:0];
        PAR_EN     = ~pen;
        PAR_TYP    = r[W];
      end
      if (chainNext && k >= len - 2) begin
        Data_Valid = 1'b1;
        P_DATA     = nextData;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
      end
    end
    if (!chainNext) begin
      @(negedge CLK);
      checkOutput("idle_busy", 32'(Busy), 32'(0));
      checkOutput("idle_mux", 32'(MUX_Sel), 32'(2'b10));
    end else begin
`ifndef UART_TX_BACK2BACK_EN
      @(negedge CLK);
      checkOutput("gap_busy", 32'(Busy), 32'(0));
      checkOutput("gap_mux", 32'(MUX_Sel), 32'(2'b10));
`endif
    end
  endtask

  initial begin
    logic [31:0] r;
    int          len;
    int          dis;
    RST        = 1'b0;
    P_DATA     = '0;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    repeat (2) @(negedge CLK);
    checkOutput("rst_mux", 32'(MUX_Sel), 32'(2'b10));
    checkOutput("rst_busy", 32'(Busy), 32'(0));
    checkOutput("rst_ser", 32'(Ser_Data), 32'(0));
    checkOutput("rst_par", 32'(Par_Bit), 32'(0));
    checkOutput("start_bit", 32'(Start_Bit), 32'(0));
    checkOutput("stop_bit", 32'(Stop_Bit), 32'(1));
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checkOutput("post_rst_busy", 32'(Busy), 32'(0));

    $display("[TB] directed frames");
    applyStimulus(8'hA5, 1'b1, 1'b0, -1, 1'b0, 8'h00, -1);
    applyStimulus(8'h01, 1'b1, 1'b1, -1, 1'b0, 8'h00, -1);
    checkOutput("par_01_odd", 32'(Par_Bit), 32'(0));
    applyStimulus(8'h03, 1'b1, 1'b1, -1, 1'b0, 8'h00, -1);
    checkOutput("par_03_odd", 32'(Par_Bit), 32'(1));
    applyStimulus(8'hFF, 1'b0, 1'b0, -1, 1'b0, 8'h00, -1);

    // Request during the 4th data cycle must be ignored.
    P_DATA = 8'h3C;
    applyStimulus(8'hA5, 1'b1, 1'b0, 4, 1'b0, 8'h00, -1);
    repeat (3) begin
      @(negedge CLK);
      checkOutput("no_ghost_busy", 32'(Busy), 32'(0));
    end

    // Reset in the 5th data cycle aborts; IDLE holds until a fresh request.
    applyStimulus(8'hA5, 1'b1, 1'b0, -1, 1'b0, 8'h00, 5);
    @(negedge CLK);
    RST = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      checkOutput("hold_busy", 32'(Busy), 32'(0));
      checkOutput("hold_mux", 32'(MUX_Sel), 32'(2'b10));
    end
    applyStimulus(8'h96, 1'b1, 1'b1, -1, 1'b0, 8'h00, -1);

    // Request held across STOP with a second word.
    applyStimulus(8'hA5, 1'b1, 1'b0, -1, 1'b1, 8'h5A, -1);
    applyStimulus(8'h5A, 1'b1, 1'b0, -1, 1'b0, 8'h00, -1);

    $display("[TB] randomized frames");
    for (int n = 0; n < 40; n++) begin
      r   = $urandom;
      len = 2 + W + int'(r[8]);
      dis = (r[10]) ? int'(r[15:12]) % (len - 1) : -1;
      applyStimulus(r[W-1:0], r[8], r[9], dis, 1'b0, 8'h00, -1);
      if (r[11]) @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
